sliding_window_histogram: RTL and testbench

Parametrised successor to the frame-FIFO histogram. Keeps per-bin occurrence counts of a DATA_W-bit sample stream over the last WIN_DEPTH accepted samples (sliding mode) or over all samples since the last clear (cumulative mode). It also provides a clear sweep, back-pressure, saturation reporting and a registered host read port. It sits between the pixel/sample front end and the statistics readout logic.

---
 rtl/sliding_window_histogram_if.sv | 30 +++
 rtl/sliding_window_histogram.sv | 173 +++++++++++++++++
 tb/tb_sliding_window_histogram.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sliding_window_histogram_if.sv
// Sample stream, clear/mode control and host read port of the sliding-window histogram.
// The master side drives samples and reads; the slave side is the histogram block.
interface sliding_window_histogram_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned WIN_AW = 6,
  parameter int unsigned CNT_W  = 7
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mode;
  logic              clear;
  logic              busy;
  logic              rd_req;
  logic [DATA_W-1:0] rd_bin;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_count;
  logic [WIN_AW:0]   win_count;
  logic              sat;

  modport master (
    output in_valid, in_data, mode, clear, rd_req, rd_bin,
    input  in_ready, busy, rd_valid, rd_count, win_count, sat
  );

  modport slave (
    input  in_valid, in_data, mode, clear, rd_req, rd_bin,
    output in_ready, busy, rd_valid, rd_count, win_count, sat
  );
endinterface

// File: rtl/sliding_window_histogram.sv
// Per-bin occurrence counts over the last WIN_DEPTH samples (sliding) or since the last
// clear (cumulative), with a bin-by-bin clear sweep and a registered host read port.
module sliding_window_histogram #(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned WIN_DEPTH = 64,
  parameter int unsigned WIN_AW    = 6,
  parameter int unsigned CNT_W     = 7
) (
  input logic                       clk,
  input logic                       rstn,
  sliding_window_histogram_if.slave hist_io
);

  localparam int unsigned       NBins   = 1 << DATA_W;
  localparam logic [CNT_W-1:0]  CntMax  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CntOne  = CNT_W'(1);
  localparam logic [WIN_AW:0]   WinFull = (WIN_AW + 1)'(WIN_DEPTH);
  localparam logic [WIN_AW:0]   WinMax  = {(WIN_AW + 1){1'b1}};
  localparam logic [DATA_W-1:0] LastBin = DATA_W'(NBins - 1);

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   sweep_q, sweep_d;
  logic                start_clear;
  logic                in_ready;
  logic                accept;

  logic                mode_q;
  logic [WIN_AW-1:0]   wr_ptr_q;
  logic [WIN_AW:0]     win_q, win_d;
  logic                sat_q;
  logic                sat_set;

  logic                s0_valid_q;
  logic [DATA_W-1:0]   s0_new_q;
  logic                s0_evict_q;
  logic [DATA_W-1:0]   old_q;

  logic [DATA_W-1:0]   win_mem [WIN_DEPTH];
  logic [CNT_W-1:0]    bins_q [NBins];
  logic [CNT_W-1:0]    bins_d [NBins];

  logic                rd_valid_q;
  logic [CNT_W-1:0]    rd_count_q;

  // Clear FSM: one bin zeroed per cycle, in index order.
  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    start_clear = 1'b0;
    case (state_q)
      StIdle: begin
        if (hist_io.clear) begin
          state_d     = StSweep;
          sweep_d     = '0;
          start_clear = 1'b1;
        end
      end
      StSweep: begin
        sweep_d = sweep_q + DATA_W'(1);
        if (sweep_q == LastBin) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready = (state_q == StIdle) && !hist_io.clear;
  assign accept   = hist_io.in_valid && in_ready;

  always_comb begin
    win_d = win_q;
    if (start_clear) begin
      win_d = '0;
    end else if (accept) begin
      if (mode_q) begin
        if (win_q != WinMax) win_d = win_q + (WIN_AW + 1)'(1);
      end else if (win_q != WinFull) begin
        win_d = win_q + (WIN_AW + 1)'(1);
      end
    end
  end

  // S1: commit the registered sample. All reads here see the committed array, so a
  // same-bin update on consecutive cycles is a plain read-modify-write with no hazard.
  always_comb begin
    bins_d  = bins_q;
    sat_set = 1'b0;
    if (s0_valid_q) begin
      if (mode_q) begin
        if (bins_q[s0_new_q] == CntMax) begin
          sat_set = 1'b1;
        end else begin
          bins_d[s0_new_q] = bins_q[s0_new_q] + CntOne;
        end
      end else if (!s0_evict_q) begin
        bins_d[s0_new_q] = bins_q[s0_new_q] + CntOne;
      end else if (s0_new_q != old_q) begin
        bins_d[s0_new_q] = bins_q[s0_new_q] + CntOne;
        bins_d[old_q]    = bins_q[old_q] - CntOne;
      end
    end
    if (state_q == StSweep) begin
      bins_d[sweep_q] = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      sweep_q    <= '0;
      mode_q     <= 1'b0;
      wr_ptr_q   <= '0;
      win_q      <= '0;
      sat_q      <= 1'b0;
      s0_valid_q <= 1'b0;
      s0_new_q   <= '0;
      s0_evict_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_count_q <= '0;
      for (int i = 0; i < int'(NBins); i++) begin
        bins_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      win_q      <= win_d;
      bins_q     <= bins_d;
      rd_valid_q <= hist_io.rd_req;
      if (hist_io.rd_req) begin
        rd_count_q <= bins_q[hist_io.rd_bin];
      end
      if (start_clear) begin
        // The S1 commit on this edge still lands in bins_d; the sweep zeroes it later.
        mode_q     <= hist_io.mode;
        wr_ptr_q   <= '0;
        sat_q      <= 1'b0;
        s0_valid_q <= 1'b0;
        s0_evict_q <= 1'b0;
      end else begin
        if (sat_set) begin
          sat_q <= 1'b1;
        end
        s0_valid_q <= accept;
        if (accept) begin
          s0_new_q   <= hist_io.in_data;
          s0_evict_q <= !mode_q && (win_q == WinFull);
          wr_ptr_q   <= wr_ptr_q + WIN_AW'(1);
        end
      end
    end
  end

  // Window memory is not reset; eviction only starts after WIN_DEPTH fresh writes.
  always_ff @(posedge clk) begin
    if (accept) begin
      old_q <= win_mem[wr_ptr_q];
      if (!mode_q) begin
        win_mem[wr_ptr_q] <= hist_io.in_data;
      end
    end
  end

  assign hist_io.in_ready  = in_ready;
  assign hist_io.busy      = (state_q == StSweep);
  assign hist_io.rd_valid  = rd_valid_q;
  assign hist_io.rd_count  = rd_count_q;
  assign hist_io.win_count = win_q;
  assign hist_io.sat       = sat_q;

endmodule

// File: tb/tb_sliding_window_histogram.sv
// Randomised and directed bench for sliding_window_histogram against a queue-based
// model of the window contents and per-bin counts.
module tb_sliding_window_histogram;

  localparam int unsigned DATA_W    = 4;
  localparam int unsigned WIN_DEPTH = 64;
  localparam int unsigned WIN_AW    = 6;
  localparam int unsigned CNT_W     = 7;
  localparam int          NB        = 16;
  localparam int          WD        = 64;
  localparam int          CMAX      = 127;
  localparam int          WMAX      = 127;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sliding_window_histogram_if #(.DATA_W(DATA_W), .WIN_AW(WIN_AW), .CNT_W(CNT_W)) hif ();

  sliding_window_histogram #(
    .DATA_W   (DATA_W),
    .WIN_DEPTH(WIN_DEPTH),
    .WIN_AW   (WIN_AW),
    .CNT_W    (CNT_W)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .hist_io(hif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts are derived from the list of committed samples.
  int m_cnt[NB];
  int m_raw[NB];
  int m_qs[$];
  bit m_busy, m_mode, m_sat, m_pend, e_rdv;
  int m_sidx, m_n, m_pval, e_rd;

  task automatic m_reset_all();
    m_busy = 0; m_mode = 0; m_sat = 0; m_pend = 0; e_rdv = 0;
    m_sidx = 0; m_n = 0; m_pval = 0; e_rd = 0;
    m_qs.delete();
    for (int b = 0; b < NB; b++) begin
      m_cnt[b] = 0;
      m_raw[b] = 0;
    end
  endtask

  task automatic m_commit(input int v);
    if (!m_mode) begin
      m_qs.push_back(v);
      if (m_qs.size() > WD) void'(m_qs.pop_front());
      for (int b = 0; b < NB; b++) m_cnt[b] = 0;
      foreach (m_qs[i]) m_cnt[m_qs[i]]++;
    end else begin
      m_raw[v]++;
      if (m_raw[v] > CMAX) m_sat = 1;
      m_cnt[v] = (m_raw[v] > CMAX) ? CMAX : m_raw[v];
    end
  endtask

  task automatic m_edge();
    bit busy_pre, acc, clr;
    busy_pre = m_busy;
    acc      = hif.in_valid && !busy_pre && !hif.clear;
    clr      = hif.clear && !busy_pre;
    e_rdv    = hif.rd_req;
    if (hif.rd_req) e_rd = m_cnt[int'(hif.rd_bin)];
    if (busy_pre) begin
      m_cnt[m_sidx] = 0;
      m_sidx++;
      if (m_sidx == NB) m_busy = 0;
    end
    if (m_pend) m_commit(m_pval);
    m_pend = acc;
    m_pval = int'(hif.in_data);
    if (acc) m_n++;
    if (clr) begin
      m_busy = 1; m_sidx = 0; m_mode = hif.mode; m_n = 0; m_sat = 0;
      m_qs.delete();
      for (int b = 0; b < NB; b++) m_raw[b] = 0;
    end
  endtask

  function automatic int exp_win();
    if (m_mode) return (m_n > WMAX) ? WMAX : m_n;
    return (m_n > WD) ? WD : m_n;
  endfunction

  initial begin
    m_reset_all();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) m_reset_all();
      else m_edge();
    end
  end

  // Per-cycle compare, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready", hif.in_ready, !m_busy && !hif.clear);
      chk("busy", hif.busy, m_busy);
      chk("rd_valid", hif.rd_valid, e_rdv);
      if (e_rdv) chk("rd_count", hif.rd_count, e_rd);
      chk("win_count", hif.win_count, exp_win());
      chk("sat", hif.sat, m_sat);
      if (rstn && dut.s0_valid_q && dut.s0_evict_q && !dut.mode_q &&
          dut.s0_new_q != dut.old_q) begin
        assert (dut.bins_q[dut.old_q] != 0)
        else begin
          n_bad++;
          $display("FAIL dec_at_zero: bin %0d got 0, expected nonzero", dut.old_q);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic read_lit(input int b, input int exp);
    hif.rd_req = 1'b1;
    hif.rd_bin = DATA_W'(b);
    @(negedge clk);
    chk($sformatf("lit_bin%0d", b), hif.rd_count, exp);
    #1;
    hif.rd_req = 1'b0;
  endtask

  task automatic stream(input int v, input int n);
    for (int i = 0; i < n; i++) begin
      hif.in_valid = 1'b1;
      hif.in_data  = DATA_W'(v);
      tick();
    end
    hif.in_valid = 1'b0;
  endtask

  task automatic do_clear(input bit md);
    int cnt;
    hif.clear = 1'b1;
    hif.mode  = md;
    #1;
    chk("in_ready_on_clear", hif.in_ready, 0);
    tick();
    hif.clear = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (hif.busy !== 1'b1) break;
      cnt++;
      if (hif.in_valid) hif.in_data = DATA_W'($urandom_range(0, NB - 1));
      tick();
    end
    chk("busy_len", cnt, NB);
  endtask

  task automatic rand_cycles(input int n, input bit allow_clr);
    for (int i = 0; i < n; i++) begin
      hif.in_valid = ($urandom_range(0, 9) < 8);
      hif.in_data  = ($urandom_range(0, 3) == 0) ? DATA_W'($urandom_range(0, 2))
                                                 : DATA_W'($urandom_range(0, NB - 1));
      hif.rd_req   = ($urandom_range(0, 2) == 0);
      hif.rd_bin   = DATA_W'($urandom_range(0, NB - 1));
      hif.clear    = allow_clr && ($urandom_range(0, 149) == 0);
      hif.mode     = 1'($urandom_range(0, 1));
      tick();
    end
    hif.in_valid = 1'b0;
    hif.rd_req   = 1'b0;
    hif.clear    = 1'b0;
  endtask

  initial begin
    hif.in_valid = 1'b0;
    hif.in_data  = '0;
    hif.mode     = 1'b0;
    hif.clear    = 1'b0;
    hif.rd_req   = 1'b0;
    hif.rd_bin   = '0;
    rstn = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();

    // Reset state
    chk("rst_in_ready", hif.in_ready, 1);
    chk("rst_busy", hif.busy, 0);
    chk("rst_win", hif.win_count, 0);
    chk("rst_sat", hif.sat, 0);
    chk("rst_rd_count", hif.rd_count, 0);
    for (int b = 0; b < NB; b++) read_lit(b, 0);

    // Sliding: 0..15 four times
    for (int i = 0; i < 64; i++) begin
      hif.in_valid = 1'b1;
      hif.in_data  = DATA_W'(i % NB);
      tick();
    end
    hif.in_valid = 1'b0;
    repeat (2) tick();
    for (int b = 0; b < NB; b++) read_lit(b, 4);
    chk("lit_win64", hif.win_count, 64);

    // 64 samples of 5 evict everything else
    stream(5, 64);
    repeat (2) tick();
    for (int b = 0; b < NB; b++) read_lit(b, (b == 5) ? 64 : 0);
    chk("lit_win64b", hif.win_count, 64);

    // Cumulative saturation
    do_clear(1'b1);
    stream(3, 130);
    repeat (2) tick();
    read_lit(3, 127);
    chk("lit_sat1", hif.sat, 1);
    chk("lit_win127", hif.win_count, 127);
    do_clear(1'b0);
    chk("lit_sat0", hif.sat, 0);
    chk("lit_win0", hif.win_count, 0);

    // Clear while streaming
    hif.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      hif.in_data = DATA_W'($urandom_range(0, NB - 1));
      tick();
    end
    do_clear(1'b0);
    stream(9, 10);
    repeat (2) tick();
    read_lit(9, 10);
    chk("lit_win10", hif.win_count, 10);

    // Reset in the middle of a sweep under random traffic
    rand_cycles(100, 1'b0);
    hif.clear = 1'b1;
    hif.mode  = 1'b0;
    tick();
    hif.clear = 1'b0;
    hif.in_valid = 1'b1;
    repeat (5) tick();
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", hif.in_ready, 1);
    chk("mid_rst_busy", hif.busy, 0);
    chk("mid_rst_rd_valid", hif.rd_valid, 0);
    chk("mid_rst_rd_count", hif.rd_count, 0);
    chk("mid_rst_win", hif.win_count, 0);
    chk("mid_rst_sat", hif.sat, 0);
    #1;
    rstn = 1'b1;
    hif.in_valid = 1'b0;
    tick();

    rand_cycles(300, 1'b0);
    rand_cycles(1500, 1'b1);
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

endmodule
